// File: rtl/result_bcd_pkg.sv
// Shared definitions for the result BCD converter: FSM states, default
// sizing, the blank digit code shown for error results, and the default
// shift-counter width.
package result_bcd_pkg;

  localparam int WIDTH_DEF  = 16;
  localparam int DIGITS_DEF = 5;
  localparam int CNT_W      = $clog2(WIDTH_DEF);

  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
// Ports: din (4-bit digit in), dout (4-bit corrected digit out). Purely
// combinational; no carry leaves the digit.
module bcd_digit_adj (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/result_bcd_converter.sv
// Captures the multiplier product on the rising edge of mul_done and
// converts it to packed BCD, one bit per cycle (result WIDTH edges after
// capture). Error results skip conversion and show all-blank digits.
// Ports: clk, reset (sync active-low), mul_done/mul_result/mul_error from
// the multiplier; bcd, bcd_valid, busy, err_flag, overrun (sticky) out.
module result_bcd_converter
  import result_bcd_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mul_done,
  input  logic [WIDTH-1:0]      mul_result,
  input  logic                  mul_error,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  bcd_valid,
  output logic                  busy,
  output logic                  err_flag,
  output logic                  overrun
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = 4*DIGITS;

  state_t            state_q, state_d;
  logic              done_q;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     bcd_q, bcd_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              ovr_q, ovr_d;

  logic              trigger;
  logic [AW-1:0]     acc_adj;
  logic [AW+WIDTH-1:0] shifted;

  // Only the first cycle of a held-high done starts anything.
  assign trigger = mul_done & ~done_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (acc_q[4*g +: 4]),
      .dout (acc_adj[4*g +: 4])
    );
  end

  // Correct all digits first, then shift the combined {acc, bin} by one.
  assign shifted = {acc_adj[AW-2:0], bin_q, 1'b0};

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE, HOLD: begin
        if (trigger) begin
          if (!mul_error) begin
            bin_d   = mul_result;
            acc_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            valid_d = 1'b0;
            err_d   = 1'b0;
            ovr_d   = 1'b0;
            state_d = CONV;
          end else begin
            bcd_d   = {DIGITS{BLANK_DIGIT}};
            err_d   = 1'b1;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            state_d = HOLD;
          end
        end
      end
      CONV: begin
        acc_d = shifted[AW+WIDTH-1:WIDTH];
        bin_d = shifted[WIDTH-1:0];
        cnt_d = cnt_q + CW'(1);
        // A new product while converting is dropped but remembered.
        if (trigger) ovr_d = 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          bcd_d   = shifted[AW+WIDTH-1:WIDTH];
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= mul_done;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bcd       = bcd_q;
  assign bcd_valid = valid_q;
  assign busy      = busy_q;
  assign err_flag  = err_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
module tb_result_bcd_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic        mul_done;
  logic [15:0] mul_result;
  logic        mul_error;
  logic [19:0] bcd;
  logic        bcd_valid;
  logic        busy;
  logic        err_flag;
  logic        overrun;

  int pass_cnt = 0;
  int total_cnt = 0;

  result_bcd_converter dut (
    .clk        (clk),
    .reset      (reset),
    .mul_done   (mul_done),
    .mul_result (mul_result),
    .mul_error  (mul_error),
    .bcd        (bcd),
    .bcd_valid  (bcd_valid),
    .busy       (busy),
    .err_flag   (err_flag),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        err;
    logic [19:0] exp_bcd;
    logic        exp_err;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: decimal digits by plain division.
  function automatic logic [19:0] to_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // One-cycle done pulse; returns edges from capture to bcd_valid.
  task automatic run_one(input logic [15:0] res, input logic err, output int lat);
    mul_result = res;
    mul_error  = err;
    mul_done   = 1'b1;
    tick();
    mul_done   = 1'b0;
    mul_error  = 1'b0;
    mul_result = ~res;
    chk("busy_after_capture", {31'd0, busy}, {31'd0, ~err});
    lat = 0;
    while (!bcd_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    vec_t vecs[8];
    int lat;
    logic [15:0] r;
    logic e;

    reset = 1'b0;
    mul_done = 1'b0;
    mul_result = '0;
    mul_error = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    chk("reset_bcd", {12'd0, bcd}, 32'd0);
    chk("reset_flags", {27'd0, bcd_valid, busy, err_flag, overrun, 1'b0}, 32'd0);

    vecs[0] = '{16'h00E1, 1'b0, 20'h00225, 1'b0};
    vecs[1] = '{16'h0000, 1'b0, 20'h00000, 1'b0};
    vecs[2] = '{16'h1234, 1'b1, 20'hFFFFF, 1'b1};
    vecs[3] = '{16'd9999, 1'b0, 20'h09999, 1'b0};
    vecs[4] = '{16'd10000, 1'b0, 20'h10000, 1'b0};
    vecs[5] = '{16'h0001, 1'b0, 20'h00001, 1'b0};
    vecs[6] = '{16'hFFFF, 1'b0, 20'h65535, 1'b0};
    vecs[7] = '{16'd40960, 1'b0, 20'h40960, 1'b0};

    for (int i = 0; i < 8; i++) begin
      run_one(vecs[i].res, vecs[i].err, lat);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].err ? 0 : 16);
      chk($sformatf("vec%0d_bcd", i), {12'd0, bcd}, {12'd0, vecs[i].exp_bcd});
      chk($sformatf("vec%0d_err", i), {31'd0, err_flag}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_busy_done", i), {31'd0, busy}, 32'd0);
      tick();
    end

    // Held-high done: exactly one conversion.
    mul_result = 16'hFFFF;
    mul_done = 1'b1;
    tick();
    chk("held_busy", {31'd0, busy}, 32'd1);
    lat = 0;
    for (int i = 1; i < 40; i++) begin
      tick();
      if (bcd_valid && lat == 0) lat = i;
    end
    mul_done = 1'b0;
    chk("held_latency", lat, 16);
    chk("held_bcd", {12'd0, bcd}, 32'h65535);
    chk("held_no_rerun", {30'd0, bcd_valid, busy}, 32'd2);
    chk("held_no_overrun", {31'd0, overrun}, 32'd0);
    tick();
    tick();
    chk("hold_stable_bcd", {12'd0, bcd}, 32'h65535);
    chk("hold_stable_valid", {31'd0, bcd_valid}, 32'd1);

    // Second pulse mid-conversion: ignored, flagged as overrun.
    mul_result = 16'h0051;
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    lat = 0;
    repeat (4) begin tick(); lat++; end
    mul_result = 16'h0009;
    mul_done = 1'b1;
    tick();
    lat++;
    mul_done = 1'b0;
    mul_result = 16'hABCD;
    chk("ovr_set_during_conv", {30'd0, overrun, busy}, 32'd3);
    while (!bcd_valid && lat < 40) begin tick(); lat++; end
    chk("ovr_latency", lat, 16);
    chk("ovr_bcd", {12'd0, bcd}, 32'h00081);
    chk("ovr_sticky", {31'd0, overrun}, 32'd1);
    tick();
    run_one(16'h0009, 1'b0, lat);
    chk("ovr_next_bcd", {12'd0, bcd}, 32'h00009);
    chk("ovr_cleared", {31'd0, overrun}, 32'd0);
    tick();

    // Reset mid-conversion discards the partial result.
    mul_result = 16'h1234;
    mul_done = 1'b1;
    tick();
    mul_done = 1'b0;
    repeat (7) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("midreset_bcd", {12'd0, bcd}, 32'd0);
    chk("midreset_flags", {28'd0, bcd_valid, busy, err_flag, overrun}, 32'd0);
    repeat (20) tick();
    chk("midreset_idle", {30'd0, bcd_valid, busy}, 32'd0);
    run_one(16'h0064, 1'b0, lat);
    chk("postreset_latency", lat, 16);
    chk("postreset_bcd", {12'd0, bcd}, 32'h00100);
    tick();

    // Randomized values against the division-based model.
    for (int i = 0; i < 24; i++) begin
      r = 16'($urandom);
      e = ($urandom_range(0, 7) == 0);
      run_one(r, e, lat);
      chk($sformatf("rnd%0d_latency", i), lat, e ? 0 : 16);
      chk($sformatf("rnd%0d_bcd_%0d", i, r), {12'd0, bcd},
          {12'd0, e ? 20'hFFFFF : to_bcd(32'(r))});
      chk($sformatf("rnd%0d_err", i), {31'd0, err_flag}, {31'd0, e});
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
